// File: rtl/fp16_mul_arb.sv
// Round-robin front end for one shared pipelined fp16 multiplier.
// Grants one requester per cycle, registers the operand pair toward the
// multiplier, tags each issue in an in-order FIFO and steers every result
// back to the requester that issued it. In-flight work is bounded by credit.
module fp16_mul_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mul_valid,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_y,
  input  logic                 mul_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [15:0]          resp_y,
  output logic                 busy,
  output logic                 err_orphan
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(TAG_DEPTH + 1);

  logic [IDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [IDW-1:0]  tag_q [TAG_DEPTH];
  logic            mul_valid_q, mul_valid_d;
  logic [15:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [15:0]     resp_y_q, resp_y_d;
  logic            orphan_q, orphan_d;

  logic            credit_ok;
  logic            xfer;
  logic [IDW-1:0]  gid;
  logic            pop;

  // Round-robin search from rr_q; credit uses the registered count only
  always_comb begin
    logic [IDW-1:0] idx;
    xfer      = 1'b0;
    gid       = '0;
    idx       = '0;
    credit_ok = !rst && (cnt_q < CW'(TAG_DEPTH));
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_q) + k) % NREQ);
      if (credit_ok && !xfer && req_valid[idx]) begin
        xfer = 1'b1;
        gid  = idx;
      end
    end
    req_ready = xfer ? (NREQ'(1) << gid) : '0;
  end

  // Next state for issue stage, tag FIFO, credit counter and response stage
  always_comb begin
    pop          = mul_ready && (cnt_q != '0);
    rr_d         = rr_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    mul_valid_d  = xfer;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_valid_d = '0;
    resp_y_d     = resp_y_q;
    orphan_d     = orphan_q | (mul_ready && (cnt_q == '0));
    cnt_d        = cnt_q + CW'(xfer) - CW'(pop);
    if (xfer) begin
      rr_d    = IDW'((32'(gid) + 1) % NREQ);
      wr_d    = wr_q + PW'(1);
      mul_a_d = req_a[32'(gid)*16 +: 16];
      mul_b_d = req_b[32'(gid)*16 +: 16];
    end
    if (pop) begin
      rd_d         = rd_q + PW'(1);
      resp_valid_d = NREQ'(1) << tag_q[rd_q];
      resp_y_d     = mul_y;
    end
  end

  // State registers; reset discards all tags and credits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= '0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      mul_valid_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_valid_q <= '0;
      resp_y_q     <= '0;
      orphan_q     <= 1'b0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      mul_valid_q  <= mul_valid_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_valid_q <= resp_valid_d;
      resp_y_q     <= resp_y_d;
      orphan_q     <= orphan_d;
      if (xfer) tag_q[wr_q] <= gid;
    end
  end

  assign mul_valid  = mul_valid_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_y     = resp_y_q;
  assign busy       = (cnt_q != '0);
  assign err_orphan = orphan_q;

endmodule

// File: tb/tb_fp16_mul_arb.sv
// Bench for fp16_mul_arb: behavioural multiplier with adjustable latency,
// a cycle model of grant/credit/orphan behaviour and a response scoreboard.
module tb_fp16_mul_arb;

  localparam int NREQ = 4;
  localparam int TD   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [16*NREQ-1:0] req_a = '0;
  logic [16*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              mul_valid;
  logic [15:0]       mul_a, mul_b;
  logic [15:0]       mul_y = '0;
  logic              mul_ready = 1'b0;
  logic [NREQ-1:0]   resp_valid;
  logic [15:0]       resp_y;
  logic              busy;
  logic              err_orphan;

  fp16_mul_arb #(.NREQ(NREQ), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_y(mul_y), .mul_ready(mul_ready),
    .resp_valid(resp_valid), .resp_y(resp_y),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [15:0] y; int cyc; } sb_t;
  typedef struct { int due; logic [15:0] y; } mq_t;
  sb_t sb[$];
  mq_t mq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int mul_lat  = 6;
  logic force_rdy = 1'b0;

  logic [3:0]  want_v = '0;
  logic [15:0] want_a [NREQ];
  logic [15:0] want_b [NREQ];

  int   rr_m = 0, infl_m = 0, last_g = -1;
  logic orph_m = 1'b0, mv_m = 1'b0;
  logic [3:0]  last_id = '0;
  logic [15:0] last_y = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Truncating fp16 multiply for normal operands; the bench's multiplier
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [6:0]  e;
    logic [9:0]  m;
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = {2'b0, a[14:10]} + {2'b0, b[14:10]} - 7'd15;
    if (p[21]) begin m = p[20:11]; e = e + 7'd1; end
    else m = p[19:10];
    return {a[15] ^ b[15], e[4:0], m};
  endfunction

  // Multiplier model and response monitor
  always @(negedge clk) begin
    mq_t e;
    sb_t s;
    logic [3:0] oh;
    if (rst) begin
      mq.delete();
      mul_ready = 1'b0;
      mul_y     = '0;
    end else begin
      if (resp_valid != '0) begin
        if (sb.size() == 0) check("resp_unexpected", 32'(resp_valid), 32'd0);
        else begin
          s  = sb.pop_front();
          oh = 4'b0001 << s.id;
          check("resp_id", 32'(resp_valid), 32'(oh));
          check("resp_y", 32'(resp_y), 32'(s.y));
          check("resp_latency", 32'(cyc - s.cyc), 32'(mul_lat + 2));
          last_id = resp_valid;
          last_y  = resp_y;
        end
      end
      if (mul_valid) begin
        e.due = cyc + mul_lat;
        e.y   = fmul(mul_a, mul_b);
        mq.push_back(e);
      end
      mul_ready = force_rdy;
      mul_y     = 16'h7BAD;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        e = mq.pop_front();
        mul_ready = 1'b1;
        mul_y     = e.y;
      end
    end
  end

  // One cycle: drive requests, check against the cycle model, advance the model
  task automatic step();
    int g;
    logic [3:0] exp_g;
    sb_t s;
    logic pop;
    @(negedge clk);
    req_valid = want_v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = want_a[i];
      req_b[16*i +: 16] = want_b[i];
    end
    #1;
    g = -1;
    exp_g = '0;
    if (infl_m < TD)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (rr_m + k) % NREQ;
        if (g < 0 && want_v[idx]) g = idx;
      end
    if (g >= 0) exp_g = 4'b0001 << g;
    check("req_ready", 32'(req_ready), 32'(exp_g));
    check("busy", 32'(busy), 32'(infl_m != 0));
    check("err_orphan", 32'(err_orphan), 32'(orph_m));
    check("mul_valid", 32'(mul_valid), 32'(mv_m));
    pop = mul_ready && (infl_m != 0);
    if (mul_ready && infl_m == 0) orph_m = 1'b1;
    if (g >= 0) begin
      s.id = g; s.y = fmul(want_a[g], want_b[g]); s.cyc = cyc;
      sb.push_back(s);
      rr_m = (g + 1) % NREQ;
      infl_m++;
    end
    if (pop) infl_m--;
    mv_m   = (g >= 0);
    last_g = g;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      want_a[i] = 16'($urandom);
      want_b[i] = 16'($urandom);
    end
  endtask

  task automatic drain();
    want_v = '0;
    for (int i = 0; i < 80 && (sb.size() != 0 || infl_m != 0); i++) step();
    step();
    check("drain_empty", 32'(sb.size() + infl_m), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_ctrl", 32'({req_ready, mul_valid, resp_valid, busy, err_orphan}), 32'd0);
    check("rst_ops", {mul_a, mul_b}, 32'd0);
    check("rst_resp_y", 32'(resp_y), 32'd0);
    want_v = '0;
    req_valid = '0;
    sb.delete();
    rr_m = 0; infl_m = 0; orph_m = 1'b0; mv_m = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int ng;
    for (int i = 0; i < NREQ; i++) begin want_a[i] = '0; want_b[i] = '0; end
    do_reset();

    // Single requester, latency 6
    want_v = 4'b0010; want_a[1] = 16'h3C00; want_b[1] = 16'h4000;
    step();
    check("t1_grant", 32'(req_ready), 32'h2);
    want_v = '0;
    step();
    check("t1_mul_a", 32'(mul_a), 32'h3C00);
    check("t1_mul_b", 32'(mul_b), 32'h4000);
    drain();
    check("t1_resp_y", 32'(last_y), 32'h4000);
    check("t1_resp_id", 32'(last_id), 32'h2);

    // All four valid for 8 cycles: strict rotation from 0
    do_reset();
    want_v = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      randomize_ops();
      step();
      check("t2_grant_order", 32'(last_g), 32'(i % NREQ));
    end
    drain();

    // Credit stall with latency 12
    mul_lat = 12;
    want_v = 4'b1111;
    ng = 0;
    for (int i = 0; i < 13; i++) begin
      randomize_ops();
      step();
      if (last_g >= 0) ng++;
    end
    check("t3_grants_before_retire", 32'(ng), 32'd8);
    for (int i = 0; i < 20; i++) begin
      randomize_ops();
      step();
      check("t3_busy", 32'(busy), 32'd1);
    end
    drain();
    mul_lat = 6;

    // Steady transfer+retire across pointer wrap
    want_v = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      randomize_ops();
      want_v = 4'($urandom_range(1, 15));
      step();
    end
    drain();

    // Orphan result
    force_rdy = 1'b1;
    step();
    force_rdy = 1'b0;
    step();
    check("orphan_set", 32'(err_orphan), 32'd1);
    want_v = 4'b0101;
    for (int i = 0; i < 6; i++) begin randomize_ops(); step(); end
    drain();
    check("orphan_sticky", 32'(err_orphan), 32'd1);

    // Reset with three in flight
    want_v = 4'b0001;
    for (int i = 0; i < 3; i++) begin randomize_ops(); step(); end
    want_v = '0;
    step();
    check("t6_busy_before_rst", 32'(busy), 32'd1);
    do_reset();
    check("t6_orphan_cleared", 32'(err_orphan), 32'd0);
    want_v = 4'b0100; want_a[2] = 16'h4200; want_b[2] = 16'h4400;
    step();
    want_v = '0;
    drain();
    check("t6_resp_id", 32'(last_id), 32'h4);
    check("t6_resp_y", 32'(last_y), 32'h4A00);
    check("t6_busy_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
